fifo_stream_reader: RTL



---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_skid_buf.sv | 60 ++++++
 rtl/fifo_stream_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side controller.
// Reader FSM states and output buffer depth.
package fifo_pkg;

    typedef enum logic [1:0] {
        RUN,
        HALTING,
        HALTED
    } reader_state_t;

    localparam int READER_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order valid/ready output buffer.
// Push and pop in the same cycle leave occupancy unchanged.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       occ_q;
    logic [2:0]       occ_next;

    // Occupancy after this cycle's push/pop; wide enough to see overflow.
    always_comb begin
        occ_next = {1'b0, occ_q} + {2'b0, push} - {2'b0, pop};
    end

    // Head/tail storage and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            occ_q <= '0;
        end else begin
            assert (occ_next <= 3'(READER_BUF_DEPTH));
            occ_q <= occ_next[1:0];
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head <= push_data;
                    else               tail <= push_data;
                end
                2'b01: head <= tail;
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (occ_q != 2'd0);
    assign data  = head;
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller feeding a valid/ready stream.
// Optional pop counter: FIFO_READER_WORD_COUNT_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_halt,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic             o_halted
`ifdef FIFO_READER_WORD_COUNT_EN
    ,
    output logic [31:0]      o_word_count
`endif
);

    reader_state_t state;
    reader_state_t state_next;
    logic          inflight;
    logic          pop;
    logic [1:0]    occ;
    logic [2:0]    held;

    assign pop = o_valid && i_ready;

    // Words owned by this block after the current pop.
    assign held = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign fifo_rd_en = !i_rst && (state == RUN) && !i_halt
                      && !fifo_empty && (held < 3'(READER_BUF_DEPTH));

    fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .valid     (o_valid),
        .data      (o_data),
        .occ       (occ)
    );

    // State register and read-in-flight tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= RUN;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fifo_rd_en;
        end
    end

    // Halt sequencing: stop reads, drain, then report halted.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (i_halt) state_next = HALTING;
            end
            HALTING: begin
                if (!i_halt)
                    state_next = RUN;
                else if (!inflight && occ == 2'd0)
                    state_next = HALTED;
            end
            HALTED: begin
                if (!i_halt) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign o_halted = (state == HALTED);

`ifdef FIFO_READER_WORD_COUNT_EN
    logic [31:0] count;

    // Count delivered words, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst)    count <= '0;
        else if (pop) count <= count + 32'd1;
    end

    assign o_word_count = count;
`endif

endmodule
